// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with its own HI/LO register pair.
//
// State | Meaning
// ------+----------------------------------------------------------
// IDLE  | ready; accepts mult/div starts and single-cycle MTHI/MTLO
// RUN   | mult/div in flight; busy high; every start is dropped
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   one-cycle strobe qualifying op
//   op       in   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   A, B     in   rs / rt operands, latched when a mult/div is accepted
//   busy     out  high while a mult/div is in flight
//   hi, lo   out  HI / LO registers
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // Datapath on the latched operands; only sampled on the completion edge.
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic                      div_zero, div_ovf;
  logic        [WIDTH-1:0]   divisor_s, divisor_u;
  logic signed [WIDTH-1:0]   quot_s, rem_s;
  logic        [WIDTH-1:0]   quot_u, rem_u;

  assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) *
                  $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  assign div_zero = (b_q == '0);
  assign div_ovf  = (a_q == MOST_NEG) && (b_q == '1);

  // Dividing by 1 instead of -1 on overflow yields exactly the required
  // result (quotient = most-negative, remainder = 0) without a wrap case.
  // The zero-divisor substitution only keeps the operators defined; that
  // result is never written.
  assign divisor_s = (div_zero || div_ovf) ? ONE : b_q;
  assign divisor_u = div_zero ? ONE : b_q;

  assign quot_s = $signed(a_q) / $signed(divisor_s);
  assign rem_s  = $signed(a_q) % $signed(divisor_s);
  assign quot_u = a_q / divisor_u;
  assign rem_u  = a_q % divisor_u;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d    = op;
              a_d     = A;
              b_d     = B;
              cnt_d   = (op == OP_MULT || op == OP_MULTU) ? MULT_N : DIV_N;
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
          case (op_q)
            OP_MULT: begin
              hi_d = prod_s[2*WIDTH-1:WIDTH];
              lo_d = prod_s[WIDTH-1:0];
            end
            OP_MULTU: begin
              hi_d = prod_u[2*WIDTH-1:WIDTH];
              lo_d = prod_u[WIDTH-1:0];
            end
            OP_DIV: begin
              if (!div_zero) begin
                hi_d = rem_s;
                lo_d = quot_s;
              end
            end
            OP_DIVU: begin
              if (!div_zero) begin
                hi_d = rem_u;
                lo_d = quot_u;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      op_q    <= 3'd0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed, table-driven bench for mdu_unit (WIDTH=32,
// MULT_CYCLES=5, DIV_CYCLES=10). Inputs change and outputs are sampled on
// the falling clock edge.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[16];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; the strobe is seen by exactly one rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
  endtask

  // Counts busy cycles, returning at the first falling edge with busy low.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic hi_held;

    vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
    vecs[4]  = '{3'd5, 32'h00000011, 32'h00000099, 32'h00000011, 32'h00000003, 0};
    vecs[5]  = '{3'd6, 32'h00000022, 32'h00000099, 32'h00000011, 32'h00000022, 0};
    vecs[6]  = '{3'd3, 32'h00001234, 32'h00000000, 32'h00000011, 32'h00000022, 10};
    vecs[7]  = '{3'd4, 32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 10};
    vecs[8]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[9]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[10] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[11] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
    vecs[12] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[13] = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 10};
    vecs[14] = '{3'd0, 32'h0000AAAA, 32'h00005555, 32'h00000001, 32'h7FFFFFFC, 0};
    vecs[15] = '{3'd7, 32'h0000BBBB, 32'h00006666, 32'h00000001, 32'h7FFFFFFC, 0};

    // Reset and idle behaviour.
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'd0;
    A       = 32'h0;
    B       = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check32("reset hi", hi, 32'h0);
    check32("reset lo", lo, 32'h0);
    check32("reset busy", {31'b0, busy}, 32'h0);
    issue(3'd0, 32'h12345678, 32'h9ABCDEF0);
    check32("op0 hi", hi, 32'h0);
    check32("op0 lo", lo, 32'h0);
    check32("op0 busy", {31'b0, busy}, 32'h0);

    // Vector table, each start issued in the first non-busy cycle.
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n);
      check_int($sformatf("vec%0d busy_cycles", i), n, vecs[i].cyc);
      check32($sformatf("vec%0d hi", i), hi, vecs[i].hi);
      check32($sformatf("vec%0d lo", i), lo, vecs[i].lo);
    end

    // Starts during busy are dropped and operands stay latched.
    issue(3'd5, 32'h00000055, 32'h0);
    check32("mthi pre hi", hi, 32'h00000055);
    issue(3'd1, 32'd6, 32'd7);
    n = 0;
    hi_held = 1'b1;
    while (busy && n < 300) begin
      if (hi !== 32'h00000055) hi_held = 1'b0;
      start = 1'b1;
      op    = 3'd5;
      A     = 32'h0000DEAD + 32'(n);
      B     = 32'(n * 3 + 1);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    op    = 3'd0;
    check_int("blocked busy_cycles", n, 5);
    check_int("blocked hi held during busy", int'(hi_held), 1);
    check32("blocked hi", hi, 32'h0);
    check32("blocked lo", lo, 32'd42);
    @(negedge clk);
    check32("blocked no late mthi", hi, 32'h0);

    // MTLO while idle.
    issue(3'd6, 32'h0000BEEF, 32'h0);
    check32("mtlo lo", lo, 32'h0000BEEF);
    check32("mtlo busy", {31'b0, busy}, 32'h0);
    check32("mtlo hi", hi, 32'h0);

    // Asynchronous reset in the 3rd busy cycle of a DIV.
    issue(3'd5, 32'h00000033, 32'h0);
    issue(3'd3, 32'd100, 32'd7);
    check32("midreset busy c1", {31'b0, busy}, 32'h1);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check32("midreset busy", {31'b0, busy}, 32'h0);
    check32("midreset hi", hi, 32'h0);
    check32("midreset lo", lo, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(3'd4, 32'd100, 32'd7);
    wait_idle(n);
    check_int("post reset busy_cycles", n, 10);
    check32("post reset hi", hi, 32'd2);
    check32("post reset lo", lo, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
